// File: rtl/vga_frame_reader.sv
// rtl/vga_frame_reader.sv - VGA scan-out of an 8-bit grayscale image window read from data memory
// 640x480@60 timing by default; the image window is fetched one read per pixel and shown as gray.
module vga_frame_reader #(
  parameter logic [31:0] BASE_ADR     = 32'h0000_1000,
  parameter int          IMG_X0       = 192,
  parameter int          IMG_Y0       = 112,
  parameter int          IMG_W        = 256,
  parameter int          IMG_H        = 256,
  parameter logic [23:0] BORDER_COLOR = 24'h000000,
  parameter int          H_ACTIVE     = 640,
  parameter int          H_SYNC_START = 656,
  parameter int          H_SYNC_END   = 752,
  parameter int          H_TOTAL      = 800,
  parameter int          V_ACTIVE     = 480,
  parameter int          V_SYNC_START = 490,
  parameter int          V_SYNC_END   = 492,
  parameter int          V_TOTAL      = 525
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_enable,
  output logic        mem_rd_en,
  output logic [31:0] mem_adr,
  input  logic [31:0] mem_rdata,
  output logic        vga_clk,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_done
);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_DONE = 10'(V_ACTIVE - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS0    = 10'(H_SYNC_START);
  localparam logic [9:0] HS1    = 10'(H_SYNC_END);
  localparam logic [9:0] VS0    = 10'(V_SYNC_START);
  localparam logic [9:0] VS1    = 10'(V_SYNC_END);
  localparam logic [9:0] WX0    = 10'(IMG_X0);
  localparam logic [9:0] WX1    = 10'(IMG_X0 + IMG_W);
  localparam logic [9:0] WY0    = 10'(IMG_Y0);
  localparam logic [9:0] WY1    = 10'(IMG_Y0 + IMG_H);

  logic        tick;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        frame_en_q;

  logic        visible;
  logic        hsync;
  logic        vsync;
  logic        in_win;
  logic        fetch;
  logic [31:0] idx;

  // Stage 1 waits for the memory read; stage 2 holds the captured byte.
  logic        s1_vis, s1_hs, s1_vs, s1_win;
  logic [1:0]  s1_lane;
  logic        s2_vis, s2_hs, s2_vs, s2_win;
  logic [7:0]  s2_pix;
  logic [7:0]  lane_byte;

  always_comb begin
    visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hsync   = (h_cnt >= HS0) && (h_cnt < HS1);
    vsync   = (v_cnt >= VS0) && (v_cnt < VS1);
    in_win  = (h_cnt >= WX0) && (h_cnt < WX1) && (v_cnt >= WY0) && (v_cnt < WY1);
    fetch   = in_win && frame_en_q;
    idx     = (32'(v_cnt) - 32'(IMG_Y0)) * 32'(IMG_W) + (32'(h_cnt) - 32'(IMG_X0));
  end

  always_comb begin
    lane_byte = mem_rdata[7:0];
    case (s1_lane)
      2'd1:    lane_byte = mem_rdata[15:8];
      2'd2:    lane_byte = mem_rdata[23:16];
      2'd3:    lane_byte = mem_rdata[31:24];
      default: lane_byte = mem_rdata[7:0];
    endcase
  end

  // vga_clk is the inverse of tick so DAC rising edges land mid-pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick       <= 1'b0;
      vga_clk    <= 1'b0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      frame_en_q <= 1'b0;
    end else begin
      tick    <= ~tick;
      vga_clk <= ~tick;
      if (tick) begin
        if (h_cnt == '0 && v_cnt == '0)
          frame_en_q <= frame_enable;
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rd_en  <= 1'b0;
      mem_adr    <= BASE_ADR;
      frame_done <= 1'b0;
    end else begin
      mem_rd_en  <= tick && fetch;
      frame_done <= tick && (h_cnt == H_LAST) && (v_cnt == V_DONE);
      if (tick && fetch)
        mem_adr <= BASE_ADR + {idx[31:2], 2'b00};
    end
  end

  // Sync flags travel active-high so cleared stages mean "not in sync".
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vis      <= 1'b0;
      s1_hs       <= 1'b0;
      s1_vs       <= 1'b0;
      s1_win      <= 1'b0;
      s1_lane     <= '0;
      s2_vis      <= 1'b0;
      s2_hs       <= 1'b0;
      s2_vs       <= 1'b0;
      s2_win      <= 1'b0;
      s2_pix      <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else if (tick) begin
      s1_vis      <= visible;
      s1_hs       <= hsync;
      s1_vs       <= vsync;
      s1_win      <= fetch;
      s1_lane     <= idx[1:0];
      s2_vis      <= s1_vis;
      s2_hs       <= s1_hs;
      s2_vs       <= s1_vs;
      s2_win      <= s1_win;
      s2_pix      <= s1_win ? lane_byte : 8'h00;
      vga_hs      <= ~s2_hs;
      vga_vs      <= ~s2_vs;
      vga_blank_n <= s2_vis;
      if (!s2_vis) begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end else if (s2_win) begin
        vga_r <= s2_pix;
        vga_g <= s2_pix;
        vga_b <= s2_pix;
      end else begin
        vga_r <= BORDER_COLOR[23:16];
        vga_g <= BORDER_COLOR[15:8];
        vga_b <= BORDER_COLOR[7:0];
      end
    end
  end

  assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb/tb_vga_frame_reader.sv - self-checking bench for vga_frame_reader on a shrunken raster
// Reference model derives every output from the clock count since reset and the frame-enable history.
module tb_vga_frame_reader;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam int          X0 = 8, Y0 = 4, W = 16, H = 12;
  localparam logic [23:0] BORDER = 24'h204060;
  localparam int          HA = 40, HSS = 44, HSE = 52, HT = 56;
  localparam int          VA = 24, VSS = 26, VSE = 28, VT = 30;
  localparam int          FRAME  = HT * VT;
  localparam int          DONE_P = (VA - 1) * HT + HT - 1;

  logic        clk = 1'b0;
  logic        reset, frame_enable;
  logic        mem_rd_en;
  logic [31:0] mem_adr, mem_rdata;
  logic        vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_done;
  logic [7:0]  vga_r, vga_g, vga_b;

  int checks = 0;
  int errors = 0;

  vga_frame_reader #(
    .BASE_ADR(BASE), .IMG_X0(X0), .IMG_Y0(Y0), .IMG_W(W), .IMG_H(H), .BORDER_COLOR(BORDER),
    .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .reset(reset), .frame_enable(frame_enable),
    .mem_rd_en(mem_rd_en), .mem_adr(mem_adr), .mem_rdata(mem_rdata),
    .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == BASE) return 32'h44332211;
    if (a == BASE + 32'(W * H - 4)) return 32'hDDCCBBAA;
    return {a[7:0] ^ 8'hA5, a[9:2] + 8'h31, ~a[7:0], a[7:0] + 8'h5C};
  endfunction

  // Read port: data valid one clk after the strobe, garbage otherwise.
  always @(posedge clk)
    mem_rdata <= mem_rd_en ? memword(mem_adr) : $urandom();

  function automatic bit win(input int p);
    int h, v;
    h = p % HT;
    v = (p / HT) % VT;
    return (h >= X0) && (h < X0 + W) && (v >= Y0) && (v < Y0 + H);
  endfunction

  function automatic int pidx(input int p);
    return ((p / HT) % VT - Y0) * W + (p % HT - X0);
  endfunction

  function automatic logic [7:0] pix(input int p);
    logic [31:0] w;
    int i;
    i = pidx(p);
    w = memword(BASE + 32'(i - i % 4)) >> (8 * (i % 4));
    return w[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model state: posedges since reset, per-frame enable, expected address register.
  int          e;
  logic [31:0] exp_adr;
  bit          fen [16];

  always @(posedge clk) begin
    int pc;
    if (reset) begin
      e = 0;
      exp_adr = BASE;
      foreach (fen[i]) fen[i] = 1'b0;
    end else begin
      e = e + 1;
      if (e % 2 == 0) begin
        pc = e / 2 - 1;
        if (pc % FRAME == 0) fen[(pc / FRAME) % 16] = frame_enable;
        if (win(pc) && fen[(pc / FRAME) % 16]) exp_adr = BASE + 32'(pidx(pc) - pidx(pc) % 4);
      end
    end
  end

  always @(negedge clk) begin : cmp
    int k, p, pc, h, v;
    bit rd, fd, vis;
    logic ehs, evs, ebl;
    logic [23:0] rgb;
    rd = 1'b0;
    fd = 1'b0;
    if (e > 0 && e % 2 == 0) begin
      pc = e / 2 - 1;
      rd = win(pc) && fen[(pc / FRAME) % 16];
      fd = (pc % FRAME) == DONE_P;
      if (rd && pc >= Y0 * HT + X0 && pc < Y0 * HT + X0 + 4)
        chk("first_word_adr", mem_adr, 32'h0000_1000);
    end
    k = (e - e % 2) / 2;
    if (k < 3) begin
      ehs = 1'b1; evs = 1'b1; ebl = 1'b0; rgb = 24'h0;
    end else begin
      p = k - 3;
      h = p % HT;
      v = (p / HT) % VT;
      vis = (h < HA) && (v < VA);
      ehs = !(h >= HSS && h < HSE);
      evs = !(v >= VSS && v < VSE);
      ebl = vis;
      if (!vis) rgb = 24'h0;
      else if (win(p) && fen[(p / FRAME) % 16]) rgb = {3{pix(p)}};
      else rgb = BORDER;
      if (p < FRAME) begin
        if (p == Y0 * HT + X0)         chk("pix_192_112", {vga_r, vga_g, vga_b}, 24'h111111);
        if (p == Y0 * HT + X0 + 1)     chk("pix_193_112", {vga_r, vga_g, vga_b}, 24'h222222);
        if (p == Y0 * HT + X0 + 2)     chk("pix_194_112", {vga_r, vga_g, vga_b}, 24'h333333);
        if (p == Y0 * HT + X0 + 3)     chk("pix_195_112", {vga_r, vga_g, vga_b}, 24'h444444);
        if (p == Y0 * HT + X0 - 1)     chk("pix_left_border", {vga_r, vga_g, vga_b}, 24'h204060);
        if (p == 15 * HT + 23)         chk("pix_last", {vga_r, vga_g, vga_b}, 24'hDDDDDD);
        if (p == 15 * HT + 24)         chk("pix_right_border", {vga_r, vga_g, vga_b}, 24'h204060);
      end
    end
    chk("vga_clk", vga_clk, e % 2 == 1);
    chk("mem_rd_en", mem_rd_en, rd);
    chk("mem_adr", mem_adr, exp_adr);
    chk("frame_done", frame_done, fd);
    chk("vga_hs", vga_hs, ehs);
    chk("vga_vs", vga_vs, evs);
    chk("vga_blank_n", vga_blank_n, ebl);
    chk("rgb", {vga_r, vga_g, vga_b}, rgb);
    chk("vga_sync_n", vga_sync_n, 1'b0);
  end

  // Pulse widths, periods and read counts measured in clk.
  int cyc = 0;
  int hs_run, hs_fall, vs_run, vs_fall, fd_last, nreads;
  int fd_cnt = 0;
  int lit_reads [4] = '{192, 192, 0, 192};
  always @(posedge clk) cyc++;

  always @(negedge clk) begin : meas
    int pc;
    if (e == 0) begin
      hs_run = 0; hs_fall = -1; vs_run = 0; vs_fall = -1; fd_last = -1; nreads = 0;
    end else begin
      if (!vga_hs) begin
        if (hs_run == 0) begin
          if (hs_fall >= 0) chk("hs_period", cyc - hs_fall, 112);
          hs_fall = cyc;
        end
        hs_run++;
      end else if (hs_run > 0) begin
        chk("hs_low_width", hs_run, 16);
        hs_run = 0;
      end
      if (!vga_vs) begin
        if (vs_run == 0) begin
          if (vs_fall >= 0) chk("vs_period", cyc - vs_fall, 3360);
          vs_fall = cyc;
        end
        vs_run++;
      end else if (vs_run > 0) begin
        chk("vs_low_width", vs_run, 224);
        vs_run = 0;
      end
      if (mem_rd_en) nreads++;
      if (frame_done) begin
        pc = e / 2 - 1;
        if (fd_last >= 0) chk("frame_done_period", cyc - fd_last, 3360);
        fd_last = cyc;
        chk("reads_per_frame", nreads, fen[(pc / FRAME) % 16] ? W * H : 0);
        if (fd_cnt < 4) chk("reads_frame_literal", nreads, lit_reads[fd_cnt]);
        fd_cnt++;
        nreads = 0;
      end
    end
  end

  task automatic wait_fd(input string what);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 4 * FRAME);
    checks++;
    if (!frame_done) begin
      errors++;
      $display("FAIL %s: frame_done not seen within %0d clk", what, n);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    frame_enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_hs", vga_hs, 1'b1);
    chk("reset_vs", vga_vs, 1'b1);
    chk("reset_blank_n", vga_blank_n, 1'b0);
    chk("reset_rd_en", mem_rd_en, 1'b0);
    chk("reset_adr", mem_adr, 32'h0000_1000);
    chk("reset_rgb", {vga_r, vga_g, vga_b}, 24'h0);
    chk("reset_vga_clk", vga_clk, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("blank_tick2", vga_blank_n, 1'b0);
    @(negedge clk);
    chk("blank_tick3", vga_blank_n, 1'b1);

    wait_fd("frame0");
    repeat (872) @(negedge clk);
    frame_enable = 1'b0;
    wait_fd("frame1");
    repeat (872) @(negedge clk);
    frame_enable = 1'b1;
    wait_fd("frame2");
    wait_fd("frame3");

    n = 0;
    while (!(e % 2 == 0 && (e / 2 - 1) % FRAME == 10 * HT + 29) && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2 * FRAME) begin
      errors++;
      $display("FAIL mid_reset_point: position (30,10) not reached");
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_rd_en", mem_rd_en, 1'b0);
    chk("midreset_blank_n", vga_blank_n, 1'b0);
    chk("midreset_adr", mem_adr, 32'h0000_1000);
    wait_fd("post_reset");
    repeat (200) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Display stage downstream of the ARM core's data memory. Reads the equalized 8-bit grayscale image from a read-only port of data memory and streams it to the VGA DAC.
- Generates 640x480@60 timing from the 50 MHz system clock using an internal divide-by-2 pixel tick.
- Places the image in a fixed window. All other visible area shows a border color.

Parameters:
- BASE_ADR, 32'h0000_1000, byte address of image pixel (0,0) in data memory
- IMG_X0, 192, first visible column of the image window
- IMG_Y0, 112, first visible row of the image window
- IMG_W, 256, image width in pixels; must be a multiple of 4
- IMG_H, 256, image height in pixels
- BORDER_COLOR, 24'h000000, {R,G,B} for visible pixels outside the window

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- frame_enable  in  1  image display enable; sampled at frame start
- mem_rd_en  out  1  read strobe to data-memory read port
- mem_adr  out  32  byte address to data-memory read port
- mem_rdata  in  32  read data; valid exactly 1 clk after mem_rd_en
- vga_clk  out  1  25 MHz pixel clock to DAC
- vga_hs  out  1  horizontal sync, active low
- vga_vs  out  1  vertical sync, active low
- vga_blank_n  out  1  high in visible area
- vga_sync_n  out  1  tied 0
- vga_r, vga_g, vga_b  out  8 each  pixel color
- frame_done  out  1  1-clk pulse at start of vertical blanking

Behaviour:
- Pixel tick:
  - `tick` toggles every clk; it is 0 in the first clk after reset.
  - All counters and output registers advance only on clocks where `tick` = 1.
  - `vga_clk` is a registered copy of ~`tick`, so rising DAC edges fall mid-pixel.
- Counters:
  - h_cnt runs 0..799 and wraps to 0.
  - v_cnt runs 0..524; it increments when h_cnt wraps and wraps to 0 after 524.
- Timing, raw and derived from the counters:
  - Visible when h_cnt < 640 and v_cnt < 480.
  - hs low for h_cnt 656..751.
  - vs low for v_cnt 490..491.
- Window: in_win when h_cnt is in [IMG_X0, IMG_X0+IMG_W) and v_cnt is in [IMG_Y0, IMG_Y0+IMG_H).
- Frame enable: frame_en_q latches frame_enable on the tick where h_cnt = 0 and v_cnt = 0. It holds for the whole frame.
- Fetch, on a tick with in_win and frame_en_q:
  - mem_rd_en = 1 for that single clk.
  - idx = (v_cnt-IMG_Y0)*IMG_W + (h_cnt-IMG_X0), computed at 32 bits.
  - mem_adr = BASE_ADR + {idx[31:2], 2'b00}.
  - Otherwise mem_rd_en = 0 and mem_adr holds its last value.
- Data capture:
  - On the clk after the read, capture the byte lane idx[1:0] of mem_rdata, little-endian (lane 0 = bits [7:0]).
  - One read is issued per in-window pixel: exactly IMG_W*IMG_H reads per enabled frame.
- Output pipeline:
  - Fixed latency of 2 pixel ticks. hs, vs, blank_n and color presented on tick k correspond to the counter state at tick k-2.
  - Sync signals are delayed through the same pipeline, so color and sync stay exactly aligned.
- Color selection:
  - Not visible: rgb = 0, blank_n = 0.
  - Visible and in_win and frame_en_q: r = g = b = the captured byte.
  - Visible otherwise: BORDER_COLOR.
- frame_done: 1-clk pulse on the tick where v_cnt changes from 479 to 480, regardless of frame_en_q.
- Reset values:
  - tick = 0, h_cnt = 0, v_cnt = 0, frame_en_q = 0.
  - vga_hs = 1, vga_vs = 1, vga_blank_n = 0, rgb = 0.
  - mem_rd_en = 0, mem_adr = BASE_ADR, frame_done = 0, vga_clk = 0.
  - All pipeline stages are cleared.
- Reset mid-line or mid-frame:
  - Reset values apply on the next clk.
  - No read strobe is issued during reset.
  - Timing restarts at (0,0) and the first frame after reset re-samples frame_enable.
- Change of frame_enable mid-frame: no effect until the next (0,0) tick.
- Wrap, last pixel of the frame (h = 799, v = 524): the next tick goes to (0,0) with no gap. The line period is 1600 clk; the frame period is 840000 clk.

Test Plan:
- Reset check: assert reset for 3 clk → all outputs at reset values, mem_rd_en = 0. Release → first visible pixel has vga_blank_n = 1 on the 3rd tick (2-tick latency).
- H/V timing check: run 2 lines → vga_hs low for exactly 192 clk, period 1600 clk. Run 1 frame → vga_vs low for 3200 clk, period 840000 clk. frame_done pulses once per frame.
- Pixel fetch and byte order: word at BASE_ADR = 32'h44332211, frame_enable = 1 → mem_adr = BASE_ADR for 4 consecutive reads. Pixels (192,112)..(195,112) are gray 11, 22, 33, 44 on all three channels. Pixel (191,112) = BORDER_COLOR.
- Window edges: word at BASE_ADR+65532 = 32'hDDCCBBAA → pixel (447,367) = gray DD, pixel (448,367) = border. Total mem_rd_en count per frame = 65536.
- Enable gating: frame_enable = 0 at (0,0) and raised mid-frame → zero reads that frame, visible area all BORDER_COLOR. Reads resume on the following frame.
- Mid-operation reset: assert reset at h = 300, v = 150 for 1 clk → outputs return to reset values on the next clk, no spurious mem_rd_en, counters restart at (0,0).
